// File: rtl/axi_addr_ch_arb.sv
// Round-robin arbiter that shares one address-translation path and one downstream
// AXI address channel among NUM_REQ requesters, one request in flight at a time.
//
// state | meaning
// IDLE  | arbitrate; grant the first valid requester at or above rr_ptr
// XLATE | t_req held with the latched address until t_done
// SEND  | translated request held on out_* until in_ready
module axi_addr_ch_arb #(
   parameter int NUM_REQ = 4,
   parameter int SRC_W   = 2
) (
   input  logic                   tx_clk,
   input  logic                   reset_,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [4*NUM_REQ-1:0]   req_id,
   input  logic [32*NUM_REQ-1:0]  req_addr,
   input  logic [8*NUM_REQ-1:0]   req_len,
   input  logic [3*NUM_REQ-1:0]   req_size,
   input  logic [2*NUM_REQ-1:0]   req_burst,
   output logic                   t_req,
   output logic [31:0]            t_vaddr,
   input  logic                   t_done,
   input  logic                   t_fault,
   input  logic [31:0]            phy_addr,
   output logic                   out_valid,
   input  logic                   in_ready,
   output logic [3:0]             out_id,
   output logic [31:0]            out_addr,
   output logic [7:0]             out_len,
   output logic [2:0]             out_size,
   output logic [1:0]             out_burst,
   output logic [SRC_W-1:0]       out_src,
   output logic                   fault_valid,
   output logic [SRC_W-1:0]       fault_src
);

   typedef enum logic [1:0] {IDLE, XLATE, SEND} state_t;

   state_t           state_q, state_d;
   logic [SRC_W-1:0] rr_ptr;
   logic [SRC_W-1:0] grant_idx;
   logic             grant_vld;
   logic [SRC_W-1:0] src_q;
   logic [31:0]      addr_q;
   logic [3:0]       id_q;
   logic [7:0]       len_q;
   logic [2:0]       size_q;
   logic [1:0]       burst_q;

   // Rotating priority scan starting at rr_ptr.
   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_REQ;
         if (!grant_vld && req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_idx = SRC_W'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready[i] = (state_q == IDLE) && grant_vld && (grant_idx == SRC_W'(i));
      end
   end

   always_ff @(posedge tx_clk or negedge reset_) begin
      if (!reset_) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      t_req   = 1'b0;
      case (state_q)
         IDLE:  if (grant_vld) state_d = XLATE;
         XLATE: begin
            t_req = 1'b1;
            if (t_done) state_d = t_fault ? IDLE : SEND;
         end
         SEND:  if (in_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign t_vaddr = addr_q;

   always_ff @(posedge tx_clk or negedge reset_) begin
      if (!reset_) begin
         rr_ptr      <= '0;
         src_q       <= '0;
         addr_q      <= '0;
         id_q        <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         out_valid   <= 1'b0;
         out_id      <= '0;
         out_addr    <= '0;
         out_len     <= '0;
         out_size    <= '0;
         out_burst   <= '0;
         out_src     <= '0;
         fault_valid <= 1'b0;
         fault_src   <= '0;
      end else begin
         fault_valid <= 1'b0;
         if (state_q == IDLE && grant_vld) begin
            src_q   <= grant_idx;
            addr_q  <= req_addr[32*grant_idx +: 32];
            id_q    <= req_id[4*grant_idx +: 4];
            len_q   <= req_len[8*grant_idx +: 8];
            size_q  <= req_size[3*grant_idx +: 3];
            burst_q <= req_burst[2*grant_idx +: 2];
            if (grant_idx == SRC_W'(NUM_REQ-1)) rr_ptr <= '0;
            else                                rr_ptr <= grant_idx + 1'b1;
         end
         // A fault takes priority: the request is dropped and only reported.
         if (state_q == XLATE && t_done) begin
            if (t_fault) begin
               fault_valid <= 1'b1;
               fault_src   <= src_q;
            end else begin
               out_valid <= 1'b1;
               out_addr  <= phy_addr;
               out_id    <= id_q;
               out_len   <= len_q;
               out_size  <= size_q;
               out_burst <= burst_q;
               out_src   <= src_q;
            end
         end
         if (state_q == SEND && in_ready) out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_addr_ch_arb.sv
// Bench for axi_addr_ch_arb: directed scenarios with literal expectations, then
// random traffic checked every cycle against a transaction-level reference model.
module tb_axi_addr_ch_arb;
   localparam int N = 4;

   logic           tx_clk;
   logic           reset_;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [4*N-1:0] req_id;
   logic [32*N-1:0] req_addr;
   logic [8*N-1:0] req_len;
   logic [3*N-1:0] req_size;
   logic [2*N-1:0] req_burst;
   logic           t_req;
   logic [31:0]    t_vaddr;
   logic           t_done;
   logic           t_fault;
   logic [31:0]    phy_addr;
   logic           out_valid;
   logic           in_ready;
   logic [3:0]     out_id;
   logic [31:0]    out_addr;
   logic [7:0]     out_len;
   logic [2:0]     out_size;
   logic [1:0]     out_burst;
   logic [1:0]     out_src;
   logic           fault_valid;
   logic [1:0]     fault_src;

   int checks = 0;
   int errors = 0;

   axi_addr_ch_arb #(.NUM_REQ(N), .SRC_W(2)) dut (
      .tx_clk(tx_clk), .reset_(reset_),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_id(req_id), .req_addr(req_addr), .req_len(req_len),
      .req_size(req_size), .req_burst(req_burst),
      .t_req(t_req), .t_vaddr(t_vaddr), .t_done(t_done), .t_fault(t_fault),
      .phy_addr(phy_addr),
      .out_valid(out_valid), .in_ready(in_ready),
      .out_id(out_id), .out_addr(out_addr), .out_len(out_len),
      .out_size(out_size), .out_burst(out_burst), .out_src(out_src),
      .fault_valid(fault_valid), .fault_src(fault_src)
   );

   initial tx_clk = 1'b0;
   always #5 tx_clk = ~tx_clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int first_from(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   // Reference model: phase 0 waiting for a grant, 1 translating, 2 presenting.
   int          m_phase;
   int          m_ptr;
   int          m_src;
   int          m_grant;
   logic [3:0]  m_id;
   logic [31:0] m_addr;
   logic [7:0]  m_len;
   logic [2:0]  m_size;
   logic [1:0]  m_burst;
   logic [31:0] m_paddr;
   logic        m_fault;
   int          m_fsrc;

   always_comb m_grant = first_from(req_valid, m_ptr);

   always @(posedge tx_clk or negedge reset_) begin
      if (!reset_) begin
         m_phase <= 0;
         m_ptr   <= 0;
         m_fault <= 1'b0;
         m_fsrc  <= 0;
      end else begin
         m_fault <= 1'b0;
         case (m_phase)
            0: if (m_grant >= 0) begin
               m_src   <= m_grant;
               m_id    <= req_id[4*m_grant +: 4];
               m_addr  <= req_addr[32*m_grant +: 32];
               m_len   <= req_len[8*m_grant +: 8];
               m_size  <= req_size[3*m_grant +: 3];
               m_burst <= req_burst[2*m_grant +: 2];
               m_ptr   <= (m_grant + 1) % N;
               m_phase <= 1;
            end
            1: if (t_done) begin
               if (t_fault) begin
                  m_fault <= 1'b1;
                  m_fsrc  <= m_src;
                  m_phase <= 0;
               end else begin
                  m_paddr <= phy_addr;
                  m_phase <= 2;
               end
            end
            default: if (in_ready) m_phase <= 0;
         endcase
      end
   end

   logic cmp_en = 1'b0;

   always @(negedge tx_clk) begin
      if (cmp_en) begin
         chk("m_req_ready", req_ready,
             (m_phase == 0 && m_grant >= 0) ? 64'(1 << m_grant) : 64'd0);
         chk("m_t_req", t_req, m_phase == 1);
         if (m_phase == 1) chk("m_t_vaddr", t_vaddr, m_addr);
         chk("m_out_valid", out_valid, m_phase == 2);
         if (m_phase == 2) begin
            chk("m_out_addr", out_addr, m_paddr);
            chk("m_out_id", out_id, m_id);
            chk("m_out_len", out_len, m_len);
            chk("m_out_size", out_size, m_size);
            chk("m_out_burst", out_burst, m_burst);
            chk("m_out_src", out_src, 64'(m_src));
         end
         chk("m_fault_valid", fault_valid, m_fault);
         if (m_fault) chk("m_fault_src", fault_src, 64'(m_fsrc));
         if (!reset_) begin
            chk("m_rst_out_addr", out_addr, 0);
            chk("m_rst_t_vaddr", t_vaddr, 0);
            chk("m_rst_fault_src", fault_src, 0);
         end
      end
   end

   int grants[$];

   task automatic step();
      @(posedge tx_clk);
      #1;
   endtask

   task automatic collect(input int n, input int bound);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < bound) begin
         @(negedge tx_clk);
         if (req_ready != 0) begin
            chk("grant_onehot", $countones(req_ready), 1);
            for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
            got++;
         end
         cyc++;
      end
      chk("grant_timeout", got, n);
   endtask

   task automatic set_req(input int i, input logic [3:0] id, input logic [31:0] a,
                          input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
      req_id[4*i +: 4]    = id;
      req_addr[32*i +: 32] = a;
      req_len[8*i +: 8]   = l;
      req_size[3*i +: 3]  = s;
      req_burst[2*i +: 2] = b;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_ = 1'b1;
      req_valid = '0; req_id = '0; req_addr = '0; req_len = '0;
      req_size = '0; req_burst = '0;
      t_done = 1'b0; t_fault = 1'b0; phy_addr = '0; in_ready = 1'b0;
      #1 reset_ = 1'b0;
      #2;
      chk("rst_t_req", t_req, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_fault_valid", fault_valid, 0);
      chk("rst_out_addr", out_addr, 0);
      repeat (3) step();
      reset_ = 1'b1;
      cmp_en = 1'b1;

      // Reset in the middle of a translation.
      step();
      set_req(1, 4'h3, 32'h2222_0000, 8'd1, 3'd2, 2'd1);
      set_req(0, 4'h9, 32'h0000_1230, 8'd3, 3'd3, 2'd1);
      req_valid = 4'b0010;
      step();
      req_valid = 4'b0000;
      #2 reset_ = 1'b0;
      #1;
      chk("midrst_t_req", t_req, 0);
      chk("midrst_t_vaddr", t_vaddr, 0);
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_req_ready", req_ready, 0);
      step();
      reset_ = 1'b1;
      req_valid = 4'b0001;
      @(negedge tx_clk);
      chk("post_rst_ready", req_ready, 4'b0001);
      step();
      req_valid = 4'b0000;
      @(negedge tx_clk);
      chk("post_rst_t_vaddr", t_vaddr, 32'h0000_1230);
      step(); t_done = 1'b1; phy_addr = 32'h4000_0000;
      step(); t_done = 1'b0; in_ready = 1'b1;
      step(); in_ready = 1'b0;

      // Single request from requester 2.
      step();
      set_req(2, 4'd5, 32'h1000_0040, 8'd7, 3'd2, 2'd1);
      req_valid = 4'b0100;
      @(negedge tx_clk);
      chk("single_ready", req_ready, 4'b0100);
      step();
      req_valid = 4'b0000;
      @(negedge tx_clk);
      chk("single_t_req", t_req, 1);
      chk("single_t_vaddr", t_vaddr, 32'h1000_0040);
      step();
      t_done = 1'b1; phy_addr = 32'h8000_0040;
      step();
      t_done = 1'b0;
      @(negedge tx_clk);
      chk("single_out_valid", out_valid, 1);
      chk("single_out_addr", out_addr, 32'h8000_0040);
      chk("single_out_id", out_id, 4'd5);
      chk("single_out_len", out_len, 8'd7);
      chk("single_out_src", out_src, 2'd2);
      step();
      t_done = 1'b1; phy_addr = 32'hDEAD_BEEF;
      @(negedge tx_clk);
      chk("single_hold1", out_valid, 1);
      step();
      t_done = 1'b0;
      @(negedge tx_clk);
      chk("single_hold2", out_valid, 1);
      chk("send_spurious_addr", out_addr, 32'h8000_0040);
      step();
      in_ready = 1'b1;
      @(negedge tx_clk);
      chk("single_last", out_valid, 1);
      step();
      in_ready = 1'b0;
      @(negedge tx_clk);
      chk("single_drop", out_valid, 0);

      // Fairness with pointer: 3 first, then 1001 gives 0 then 3.
      step();
      t_done = 1'b1; in_ready = 1'b1;
      req_valid = 4'b1000;
      grants.delete();
      collect(1, 10);
      step();
      req_valid = 4'b1001;
      collect(2, 20);
      step();
      req_valid = 4'b0000;
      repeat (4) step();
      chk("fair_count", grants.size(), 3);
      if (grants.size() == 3) begin
         chk("fair_g0", grants[0], 3);
         chk("fair_g1", grants[1], 0);
         chk("fair_g2", grants[2], 3);
      end

      // Round robin with all four valid and zero-latency translation.
      grants.delete();
      req_valid = 4'b1111;
      collect(5, 40);
      step();
      req_valid = 4'b0000;
      repeat (4) step();
      t_done = 1'b0; in_ready = 1'b0;
      chk("rr_count", grants.size(), 5);
      if (grants.size() == 5) begin
         chk("rr_g0", grants[0], 0);
         chk("rr_g1", grants[1], 1);
         chk("rr_g2", grants[2], 2);
         chk("rr_g3", grants[3], 3);
         chk("rr_g4", grants[4], 0);
      end

      // Translation fault on requester 1.
      step();
      req_valid = 4'b0010;
      @(negedge tx_clk);
      chk("fault_grant", req_ready, 4'b0010);
      step();
      req_valid = 4'b1001;
      t_done = 1'b1; t_fault = 1'b1;
      @(negedge tx_clk);
      chk("fault_xlate_ready", req_ready, 0);
      step();
      t_done = 1'b0; t_fault = 1'b0;
      @(negedge tx_clk);
      chk("fault_valid", fault_valid, 1);
      chk("fault_src", fault_src, 2'd1);
      chk("fault_no_out", out_valid, 0);
      chk("fault_next_grant", req_ready, 4'b1000);
      step();
      req_valid = 4'b0000;
      @(negedge tx_clk);
      chk("fault_pulse_end", fault_valid, 0);
      chk("fault_next_t_req", t_req, 1);
      step(); t_done = 1'b1;
      step(); t_done = 1'b0; in_ready = 1'b1;
      step(); in_ready = 1'b0;

      // Spurious t_done and in_ready while idle.
      step();
      t_done = 1'b1; in_ready = 1'b1;
      @(negedge tx_clk);
      chk("idle_spur_t_req", t_req, 0);
      chk("idle_spur_out", out_valid, 0);
      step();
      t_done = 1'b0;
      @(negedge tx_clk);
      chk("idle_spur_t_req2", t_req, 0);
      chk("idle_spur_fault", fault_valid, 0);
      step();
      in_ready = 1'b0;

      // Random traffic.
      for (int c = 0; c < 3000; c++) begin
         step();
         req_valid = 4'($urandom_range(0, 15));
         req_id    = 16'($urandom);
         req_addr  = {$urandom, $urandom, $urandom, $urandom};
         req_len   = $urandom;
         req_size  = 12'($urandom);
         req_burst = 8'($urandom);
         t_done    = ($urandom_range(0, 2) == 0);
         t_fault   = ($urandom_range(0, 3) == 0);
         phy_addr  = $urandom;
         in_ready  = ($urandom_range(0, 1) == 0);
      end
      step();
      @(negedge tx_clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_addr_ch_arb.md
# axi_addr_ch_arb

Round-robin arbiter and sequencer that shares one address-translation path and one downstream AXI address channel among `NUM_REQ` upstream address-channel requesters. It accepts one request at a time and presents the virtual address to the translation logic. On successful translation it drives the physical address and the request attributes onto the downstream channel, then returns to arbitration. It sits in the MMU between the requester ports and the translated-address transmit stage.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8).
- `SRC_W`, 2, requester index width; must equal clog2(`NUM_REQ`).
- `tx_clk` in 1: sole clock, rising edge.
- `reset_` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester accept, one-hot or zero.
- `req_id` in 4*`NUM_REQ`: requester i's ID, in bits [4i+3:4i].
- `req_addr` in 32*`NUM_REQ`: virtual address per requester.
- `req_len` in 8*`NUM_REQ`: burst length per requester.
- `req_size` in 3*`NUM_REQ`: burst size per requester.
- `req_burst` in 2*`NUM_REQ`: burst type per requester.
- `t_req` out 1: translation request, level.
- `t_vaddr` out 32: address to translate.
- `t_done` in 1: translation complete, single-cycle pulse.
- `t_fault` in 1: qualifies `t_done` as a failed translation.
- `phy_addr` in 32: translated address, valid with `t_done`.
- `out_valid` out 1: downstream address valid.
- `in_ready` in 1: downstream accept.
- `out_id`, `out_addr`, `out_len`, `out_size`, `out_burst` out 4/32/8/3/2: downstream fields.
- `out_src` out `SRC_W`: index of the granted requester.
- `fault_valid` out 1: single-cycle fault report.
- `fault_src` out `SRC_W`: requester whose translation faulted.

## Operation
- FSM states: IDLE, XLATE, SEND.
- **IDLE**
  - If any `req_valid` is set, grant the first set index scanning upward from `rr_ptr`, wrapping modulo `NUM_REQ`.
  - `req_ready[g]` is a combinational decode of (state==IDLE and grant==g). The handshake completes on that edge.
  - On that edge: latch the grantee's id/addr/len/size/burst and g, set `rr_ptr` to (g+1) mod `NUM_REQ`, and go to XLATE.
  - If no `req_valid` is set, stay in IDLE and leave `rr_ptr` unchanged.
- **XLATE**
  - `t_req`=1 and `t_vaddr`=latched addr, held stable until `t_done`.
  - On `t_done` with `t_fault`=0: register `phy_addr` into `out_addr`, drive the latched fields onto `out_*`, set `out_src`=g and `out_valid`=1, and go to SEND.
  - On `t_done` with `t_fault`=1: set `fault_valid`=1 for one cycle with `fault_src`=g, do not assert `out_valid`, and go to IDLE.
- **SEND**
  - Hold `out_valid` and every `out_*` field stable until `in_ready`.
  - On `out_valid & in_ready`: clear `out_valid` and go to IDLE.
- `req_ready` is all-zero outside IDLE.
- `t_done` outside XLATE is ignored.
- `in_ready` without `out_valid` is ignored.
- Latched request fields do not change while in XLATE or SEND.

## Timing
- Asynchronous reset values: state=IDLE, `rr_ptr`=0, all `out_*`=0, `out_valid`=0, `t_req`=0, `t_vaddr`=0, `fault_valid`=0, `fault_src`=0.
- Reset mid-operation aborts the transaction with no report. A requester must re-present after reset.
- Grant at edge 0 gives `t_req`=1 from cycle 1.
- `t_done` at edge k gives `out_valid`=1 from cycle k+1.
- Minimum turnaround from grant to next grant is 3 cycles, with `t_done` in cycle 1 and `in_ready` already high.
- `fault_valid` is high for exactly the one cycle after the faulting `t_done`. IDLE can grant in that same cycle.
- Fairness: a requester that stays valid is granted within `NUM_REQ` grants.
- Simultaneous `t_done` and `t_fault`: fault path wins.
- A requester dropping `req_valid` before its grant is legal and is simply skipped.

## Test plan
- **Reset defaults:** assert `reset_`=0 mid-XLATE → all outputs 0 asynchronously, state IDLE. After release with `req_valid`=0001 → `req_ready`=0001 on the first edge.
- **Single request:** requester 2 sends addr 0x1000_0040, id 5, len 7; `t_done` with `phy_addr` 0x8000_0040 two cycles later.
  - `t_vaddr` must read 0x1000_0040.
  - `out_addr`=0x8000_0040, `out_id`=5, `out_len`=7, `out_src`=2.
  - `out_valid` holds for 3 cycles of `in_ready`=0 and drops the cycle after `in_ready`=1.
- **Round-robin:** `req_valid`=1111 held, zero-latency translation → grant order 0,1,2,3,0, one `req_ready` pulse each.
- **Fairness with pointer:** after requester 3 is granted, `req_valid`=1001 → requester 0 is granted next, then requester 3.
- **Fault:** `t_done`=1 with `t_fault`=1 for requester 1 → `fault_valid` pulse with `fault_src`=1, no `out_valid`, next grant goes to the next valid requester.
- **Spurious inputs:** `t_done` pulsed in IDLE and in SEND, `in_ready` held high in IDLE → no state change and no outputs.
